// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the register file's single write port between NUM_REQ result
//   producers with round-robin arbitration. The winning request is registered
//   onto the write port one cycle after acceptance. A pending-write scoreboard
//   (one bit per register) tracks reserved destinations so issue logic can
//   detect RAW/WAW hazards.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready     per-requester write handshake (ready is one-hot or zero)
//   req_reg/req_data        packed per-requester destination index and data
//   rsv_valid/rsv_reg       reservation request from issue; rsv_ready accepts it
//   chk_reg1/chk_reg2       hazard-check indices; chk_busy1/chk_busy2 report pending
//   rf_write_*              registered write port to the register file
//   pending_mask            scoreboard state, bit r = register r reserved
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. A requester holds valid, reg and data stable until accepted; ready never
// depends on the requester's own ready, only on valids and the round-robin
// pointer. rsv_valid/rsv_ready follows the same rule.
module regfile_write_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_reg,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  input  logic                           rsv_valid,
  input  logic [ADDR_WIDTH-1:0]          rsv_reg,
  output logic                           rsv_ready,
  input  logic [ADDR_WIDTH-1:0]          chk_reg1,
  input  logic [ADDR_WIDTH-1:0]          chk_reg2,
  output logic                           chk_busy1,
  output logic                           chk_busy2,
  output logic                           rf_write_enable,
  output logic [ADDR_WIDTH-1:0]          rf_write_reg,
  output logic [DATA_WIDTH-1:0]          rf_write_data,
  output logic [2**ADDR_WIDTH-1:0]       pending_mask
);

  localparam int NUM_REGS = 2**ADDR_WIDTH;
  localparam int PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]      last_grant;
  logic [PTR_W-1:0]      grant_idx;
  logic [PTR_W-1:0]      idx;
  logic [NUM_REQ-1:0]    grant;
  logic                  found;
  logic                  transfer;
  logic [ADDR_WIDTH-1:0] sel_reg;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  rsv_fire;
  logic [NUM_REGS-1:0]   pending_next;

  // Round-robin search starting one past the last winner, wrapping around.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    found     = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = PTR_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        found      = 1'b1;
      end
    end
  end

  assign req_ready = reset ? grant : '0;
  assign transfer  = |req_ready;
  assign sel_reg   = req_reg[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_data  = req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant      <= PTR_W'(NUM_REQ - 1);
      rf_write_enable <= 1'b0;
      rf_write_reg    <= '0;
      rf_write_data   <= '0;
    end else begin
      rf_write_enable <= transfer;
      if (transfer) begin
        last_grant    <= grant_idx;
        rf_write_reg  <= sel_reg;
        rf_write_data <= sel_data;
      end
    end
  end

  // Scoreboard. A pending register stalls a new reservation (no WAW).
  assign rsv_ready = reset & ~pending_mask[rsv_reg];
  assign rsv_fire  = rsv_valid & rsv_ready;
  assign chk_busy1 = pending_mask[chk_reg1];
  assign chk_busy2 = pending_mask[chk_reg2];

  // Clear on commit first, then set, so a same-edge reservation wins.
  always_comb begin
    pending_next = pending_mask;
    if (rf_write_enable) pending_next[rf_write_reg] = 1'b0;
    if (rsv_fire)        pending_next[rsv_reg]      = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending_mask <= '0;
    else        pending_mask <= pending_next;
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  localparam int NUM_REQ    = 3;
  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 4;
  localparam int W          = ADDR_WIDTH + DATA_WIDTH;

  logic                          clk;
  logic                          reset;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_reg;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          rsv_valid;
  logic [ADDR_WIDTH-1:0]         rsv_reg;
  logic                          rsv_ready;
  logic [ADDR_WIDTH-1:0]         chk_reg1;
  logic [ADDR_WIDTH-1:0]         chk_reg2;
  logic                          chk_busy1;
  logic                          chk_busy2;
  logic                          rf_write_enable;
  logic [ADDR_WIDTH-1:0]         rf_write_reg;
  logic [DATA_WIDTH-1:0]         rf_write_data;
  logic [2**ADDR_WIDTH-1:0]      pending_mask;

  logic [W-1:0] exp_q[$];
  int compared   = 0;
  int mismatched = 0;

  logic [ADDR_WIDTH-1:0] rr_reg[NUM_REQ];
  logic [DATA_WIDTH-1:0] rr_data[NUM_REQ];

  regfile_write_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_reg(req_reg), .req_data(req_data),
    .rsv_valid(rsv_valid), .rsv_reg(rsv_reg), .rsv_ready(rsv_ready),
    .chk_reg1(chk_reg1), .chk_reg2(chk_reg2),
    .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
    .rf_write_enable(rf_write_enable), .rf_write_reg(rf_write_reg),
    .rf_write_data(rf_write_data), .pending_mask(pending_mask)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [ADDR_WIDTH-1:0] r,
                         input logic [DATA_WIDTH-1:0] d);
    req_reg[i*ADDR_WIDTH +: ADDR_WIDTH]  = r;
    req_data[i*DATA_WIDTH +: DATA_WIDTH] = d;
  endtask

  task automatic push_exp(input logic [ADDR_WIDTH-1:0] r, input logic [DATA_WIDTH-1:0] d);
    exp_q.push_back({r, d});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every committed write must match the next expected one.
  always @(negedge clk) begin
    if (reset && rf_write_enable) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL write_unexpected: got reg %0h data %0h expected none",
                 rf_write_reg, rf_write_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({rf_write_reg, rf_write_data} !== e) begin
          mismatched++;
          $display("FAIL write_data: got reg %0h data %0h expected reg %0h data %0h",
                   rf_write_reg, rf_write_data, e[W-1:DATA_WIDTH], e[DATA_WIDTH-1:0]);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NUM_REQ-1:0] one_hot;
    reset     = 1'b0;
    req_valid = '0;
    req_reg   = '0;
    req_data  = '0;
    rsv_valid = 1'b0;
    rsv_reg   = '0;
    chk_reg1  = '0;
    chk_reg2  = '0;
    rr_reg[0] = 4'h1; rr_data[0] = 16'h1111;
    rr_reg[1] = 4'h2; rr_data[1] = 16'h2222;
    rr_reg[2] = 4'h3; rr_data[2] = 16'h3333;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, rr_reg[i], rr_data[i]);
    req_valid = 3'b111;

    // Reset state with all requesters valid
    step();
    step();
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_we", 32'(rf_write_enable), 32'h0);
    check("rst_wreg", 32'(rf_write_reg), 32'h0);
    check("rst_wdata", 32'(rf_write_data), 32'h0);
    check("rst_pending", 32'(pending_mask), 32'h0);
    check("rst_rsv_ready", 32'(rsv_ready), 32'h0);
    #4 reset = 1'b1;
    #1 check("post_rst_ready", 32'(req_ready), 32'h1);

    // Round robin with everyone valid: 0,1,2,0,1,2
    for (int k = 0; k < 6; k++) begin
      if (k > 0) check("rr_we", 32'(rf_write_enable), 32'h1);
      one_hot = 3'b001 << (k % NUM_REQ);
      check("rr_grant", 32'(req_ready), 32'(one_hot));
      push_exp(rr_reg[k % NUM_REQ], rr_data[k % NUM_REQ]);
      step();
    end
    req_valid = '0;
    check("rr_last_we", 32'(rf_write_enable), 32'h1);
    step();
    check("rr_idle_we", 32'(rf_write_enable), 32'h0);

    // Mid-run reset drops the in-flight write and clears the scoreboard
    rsv_valid = 1'b1;
    rsv_reg   = 4'h9;
    step();
    rsv_valid = 1'b0;
    check("rsv_r9", 32'(pending_mask), 32'h0200);
    req_valid = 3'b111;
    step();
    #2 reset = 1'b0;
    #1;
    check("mid_rst_we", 32'(rf_write_enable), 32'h0);
    check("mid_rst_wreg", 32'(rf_write_reg), 32'h0);
    check("mid_rst_wdata", 32'(rf_write_data), 32'h0);
    check("mid_rst_pending", 32'(pending_mask), 32'h0);
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    #2 reset = 1'b1;
    #1 check("mid_post_ready", 32'(req_ready), 32'h1);
    req_valid = '0;
    step();

    // Requester 1 alone
    set_req(1, 4'h5, 16'hBEEF);
    req_valid = 3'b010;
    #1 check("r1_grant", 32'(req_ready), 32'h2);
    push_exp(4'h5, 16'hBEEF);
    step();
    req_valid = '0;
    check("r1_we", 32'(rf_write_enable), 32'h1);
    check("r1_wreg", 32'(rf_write_reg), 32'h5);
    check("r1_wdata", 32'(rf_write_data), 32'hBEEF);
    step();
    check("r1_we_off", 32'(rf_write_enable), 32'h0);
    check("r1_hold_reg", 32'(rf_write_reg), 32'h5);
    check("r1_hold_data", 32'(rf_write_data), 32'hBEEF);

    // Reserve R3, stall second reservation, clear on commit
    rsv_valid = 1'b1;
    rsv_reg   = 4'h3;
    #1 check("r3_rsv_ready", 32'(rsv_ready), 32'h1);
    step();
    chk_reg1 = 4'h3;
    chk_reg2 = 4'h4;
    #1;
    check("r3_pending", 32'(pending_mask), 32'h0008);
    check("r3_busy1", 32'(chk_busy1), 32'h1);
    check("r4_busy2", 32'(chk_busy2), 32'h0);
    check("r3_stall", 32'(rsv_ready), 32'h0);
    step();
    rsv_valid = 1'b0;
    check("r3_pending_held", 32'(pending_mask), 32'h0008);
    set_req(0, 4'h3, 16'h1234);
    req_valid = 3'b001;
    #1 check("r3_wr_grant", 32'(req_ready), 32'h1);
    push_exp(4'h3, 16'h1234);
    step();
    req_valid = '0;
    check("r3_busy_commit_cycle", 32'(chk_busy1), 32'h1);
    step();
    check("r3_cleared", 32'(pending_mask), 32'h0);
    check("r3_busy1_off", 32'(chk_busy1), 32'h0);
    check("r3_rsv_ready_again", 32'(rsv_ready), 32'h1);

    // Set and clear of R7 on the same edge: set wins
    set_req(2, 4'h7, 16'h7777);
    req_valid = 3'b100;
    #1 check("r7_grant", 32'(req_ready), 32'h4);
    push_exp(4'h7, 16'h7777);
    step();
    req_valid = '0;
    rsv_valid = 1'b1;
    rsv_reg   = 4'h7;
    #1 check("r7_rsv_ready", 32'(rsv_ready), 32'h1);
    step();
    rsv_valid = 1'b0;
    check("r7_set_wins", 32'(pending_mask), 32'h0080);

    // Requester 2 loses to requester 0, holds, then is granted
    set_req(0, 4'hA, 16'h0A0A);
    set_req(2, 4'hB, 16'hC0DE);
    req_valid = 3'b101;
    #1 check("wait_grant0", 32'(req_ready), 32'h1);
    push_exp(4'hA, 16'h0A0A);
    push_exp(4'hB, 16'hC0DE);
    step();
    req_valid = 3'b100;
    #1 check("wait_grant2", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    step();
    step();

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between NUM_REQ result producers (ALU, load unit, multiplier).
- Requesters are served round-robin over a valid/ready handshake; the winner is registered onto the write port.
- Holds a 16-entry pending-write scoreboard: issue logic reserves a destination register, and the reservation clears when that register's write commits.
- Issue logic reads the scoreboard to detect RAW/WAW hazards on the two read ports.

Parameters:
NUM_REQ, 3, number of write requesters (2..8)
DATA_WIDTH, 16, register data width
ADDR_WIDTH, 4, register index width; register count = 2**ADDR_WIDTH (16)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  NUM_REQ  requester i has a write pending
req_ready  output  NUM_REQ  requester i granted this cycle; one-hot or zero
req_reg  input  NUM_REQ*ADDR_WIDTH  destination index, requester i in slice [i*ADDR_WIDTH +: ADDR_WIDTH]
req_data  input  NUM_REQ*DATA_WIDTH  write data, requester i in slice [i*DATA_WIDTH +: DATA_WIDTH]
rsv_valid  input  1  issue stage requests reservation of rsv_reg
rsv_reg  input  ADDR_WIDTH  register to reserve
rsv_ready  output  1  reservation accepted this cycle
chk_reg1  input  ADDR_WIDTH  hazard-check index 1
chk_reg2  input  ADDR_WIDTH  hazard-check index 2
chk_busy1  output  1  chk_reg1 has a pending write
chk_busy2  output  1  chk_reg2 has a pending write
rf_write_enable  output  1  to register file write_enable
rf_write_reg  output  ADDR_WIDTH  to register file write_reg
rf_write_data  output  DATA_WIDTH  to register file write_data
pending_mask  output  2**ADDR_WIDTH  scoreboard state, bit r = register r reserved

Behaviour:
Reset (reset low, asynchronous):
- pending_mask = 0, rf_write_enable = 0, rf_write_reg = 0, rf_write_data = 0.
- Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has highest priority after reset.
- req_ready and rsv_ready are forced to 0 while reset is low.
- A transfer in flight when reset asserts is dropped; no write is issued.

Arbitration:
- Search order starts at (last_grant+1) mod NUM_REQ and wraps around.
- req_ready[i] is combinational and goes high only for the first requester in search order with req_valid[i]=1. If no requester is valid, req_ready = 0.
- A transfer occurs when req_valid[i] & req_ready[i] at a rising edge. On a transfer, last_grant <= i; otherwise last_grant holds.
- Once req_valid is asserted, the requester must keep req_valid, req_reg and req_data stable until it is accepted. req_ready must not depend on its own value.

Write stage (1-cycle latency):
- The edge that accepts a transfer registers rf_write_enable=1 and captures req_reg/req_data into rf_write_reg/rf_write_data.
- A cycle with no transfer registers rf_write_enable=0; rf_write_reg and rf_write_data hold their last values.
- The register file never back-pressures, so sustained throughput is one write per cycle.

Scoreboard:
- rsv_ready = ~pending_mask[rsv_reg] (combinational; gated by reset). Reserving a register that is already pending is stalled, which prevents WAW.
- At an edge with rsv_valid & rsv_ready, pending_mask[rsv_reg] <= 1.
- At an edge with rf_write_enable=1, pending_mask[rf_write_reg] <= 0. This is the same edge at which the register file stores the data.
- If a set and a clear hit the same register on the same edge, the set wins.
- Writes to registers that are not reserved are legal; the clear is a no-op.
- All 2**ADDR_WIDTH registers, including register 0, are treated uniformly.
- chk_busy1 = pending_mask[chk_reg1] and chk_busy2 = pending_mask[chk_reg2]; both combinational, no bypass.
  - The busy bit drops on the commit edge.
  - Consequently a read issued the following cycle sees the new data.

Test Plan:
- Reset low mid-run with req_valid=3'b111 -> all outputs and pending_mask 0 immediately; req_ready=0. After release, req_ready=3'b001.
- req_valid=3'b111 held, each requester re-asserting after acceptance -> grants 0,1,2,0,1,2 on consecutive cycles. rf_write_enable high continuously from cycle 2, with rf_write_reg/rf_write_data matching each requester one cycle after its grant.
- Requester 1 alone: reg=4'h5, data=16'hBEEF -> req_ready=3'b010 the same cycle; the next cycle rf_write_enable=1, rf_write_reg=5, rf_write_data=16'hBEEF; the following cycle rf_write_enable=0.
- Reserve R3 -> pending_mask=16'h0008, chk_busy1=1 for chk_reg1=3. A second reservation of R3 sees rsv_ready=0. After a write to R3 commits, the bit clears and rsv_ready=1.
- Same edge: reserve R7 while an unreserved write to R7 commits -> pending_mask[7]=1 (set wins).
- Requester 2 valid but requester 0 wins the grant -> requester 2 holds req_valid with stable data and is granted the next cycle; data arrives unchanged on rf_write_data.
